// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// The asynchronous rx pin is double-flopped, then oversampled at 16x the baud rate.
// Each bit value is the majority of the samples taken at ticks 7, 8 and 9 of that bit.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   en        receiver enable; low freezes the tick counter, index counter and FSM
//   rx        asynchronous serial input, idle high
//   rx_data   last good byte; held until the next good frame completes
//   rx_valid  one-cycle pulse when rx_data is updated
//   frame_err one-cycle pulse when the stop bit is sampled low
//   rx_busy   high while a frame is in progress
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  // Clock cycles per oversample tick; must be at least 1.
  localparam int unsigned OS_DIVISOR = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam logic [15:0] TickMax    = 16'(OS_DIVISOR - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  samp_q, samp_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        active;
  logic        tick;
  logic [3:0]  idx_next;
  logic        majority;
  logic        eval;

  // Synchronizer runs regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign active   = en && (state_q != StIdle);
  assign tick     = active && (tick_cnt_q == TickMax);
  assign idx_next = idx_q + 4'd1;
  // samp_q holds the tick-7 and tick-8 samples; the tick-9 sample is rx_s_q itself.
  assign majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign eval     = tick && (idx_next == 4'd9);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    idx_d      = idx_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (active) begin
      tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    end

    if (tick) begin
      idx_d = idx_next;
      if (idx_next == 4'd7) samp_d[0] = rx_s_q;
      if (idx_next == 4'd8) samp_d[1] = rx_s_q;
    end

    case (state_q)
      StIdle: begin
        if (en && !rx_s_q) begin
          state_d    = StStart;
          tick_cnt_d = 16'd0;
          idx_d      = 4'd0;
        end
      end
      StStart: begin
        if (eval) begin
          if (!majority) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end else begin
            // False start: drop back silently.
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (eval) begin
          shift_d   = {majority, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (eval) begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          state_d = StIdle;
          if (majority) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= 16'd0;
      idx_q      <= 4'd0;
      bit_cnt_q  <= 3'd0;
      samp_q     <= 2'b00;
      shift_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != StIdle);

endmodule
